// File: rtl/dram_ctrl.sv
// dram_ctrl: turns single-word bus reads/writes into DRAM ACT/PRE/READ/WRITE
// command sequences. One row is left open between requests (open-page policy).
//
// state | meaning
// IDLE  | waiting for a request; held off while a response is still pending
// PRE   | PRE on the pins, counting out TRP before ACT
// ACT   | ACT on the pins, counting out TRCD before READ/WRITE
// CMD   | READ or WRITE on the pins this cycle
// RWAIT | waiting for DRAM_valid to return the read word
// WREC  | write recovery, TWR cycles before another command may go out
module dram_ctrl #(
  parameter int TRCD = 5,
  parameter int TRP  = 5,
  parameter int TWR  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        DRAM_CSn,
  output logic        DRAM_RASn,
  output logic        DRAM_CASn,
  output logic [3:0]  DRAM_WEn,
  output logic [10:0] DRAM_A,
  output logic [31:0] DRAM_D,
  input  logic [31:0] DRAM_Q,
  input  logic        DRAM_valid
);

  localparam int MAX_D = (TRCD > TRP) ? ((TRCD > TWR) ? TRCD : TWR)
                                      : ((TRP  > TWR) ? TRP  : TWR);
  localparam int CNT_W = $clog2(MAX_D + 1);

  // Timed states are entered with delay-1 so the state exits on terminal count
  // and the following command lands exactly the full delay after the previous one.
  localparam logic [CNT_W-1:0] TRCD_LD = CNT_W'(TRCD - 1);
  localparam logic [CNT_W-1:0] TRP_LD  = CNT_W'(TRP - 1);
  localparam logic [CNT_W-1:0] TWR_LD  = CNT_W'(TWR - 1);

  typedef enum logic [2:0] {IDLE, PRE, ACT, CMD, RWAIT, WREC} state_t;
  typedef enum logic [2:0] {C_NOP, C_ACT, C_PRE, C_READ, C_WRITE} cmd_t;

  state_t           state, state_nxt;
  cmd_t             cmd_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             row_open, row_open_nxt;
  logic [10:0]      open_row, open_row_nxt;

  logic             lat_write;
  logic [10:0]      lat_row;
  logic [9:0]       lat_col;
  logic [3:0]       lat_wstrb;
  logic [31:0]      lat_wdata;

  logic             accept;
  logic             resp_set_rd;
  logic             resp_set_wr;

  logic             cur_write;
  logic [10:0]      cur_row;
  logic [9:0]       cur_col;
  logic [3:0]       cur_wstrb;
  logic [31:0]      cur_wdata;

  logic             unused_addr;
  assign unused_addr = ^{req_addr[31:23], req_addr[1:0]};

  // Back-to-back: the retiring response frees the slot in the same cycle.
  assign req_ready = !rst && (state == IDLE) && (!resp_valid || resp_ready);
  assign accept    = req_valid && req_ready;

  // In IDLE the first command is registered on the accept edge, before the
  // request latches hold the new values, so read straight from the bus there.
  assign cur_write = (state == IDLE) ? req_write        : lat_write;
  assign cur_row   = (state == IDLE) ? req_addr[22:12]  : lat_row;
  assign cur_col   = (state == IDLE) ? req_addr[11:2]   : lat_col;
  assign cur_wstrb = (state == IDLE) ? req_wstrb        : lat_wstrb;
  assign cur_wdata = (state == IDLE) ? req_wdata        : lat_wdata;

  // State register, delay counter and open-row tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      row_open <= 1'b0;
      open_row <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      row_open <= row_open_nxt;
      open_row <= open_row_nxt;
    end
  end

  // Next state, command to issue, counter loads and response triggers.
  always_comb begin
    state_nxt    = state;
    cmd_nxt      = C_NOP;
    cnt_nxt      = (cnt != '0) ? cnt - 1'b1 : '0;
    row_open_nxt = row_open;
    open_row_nxt = open_row;
    resp_set_rd  = 1'b0;
    resp_set_wr  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!row_open) begin
            state_nxt    = ACT;
            cmd_nxt      = C_ACT;
            cnt_nxt      = TRCD_LD;
            row_open_nxt = 1'b1;
            open_row_nxt = cur_row;
          end else if (cur_row != open_row) begin
            state_nxt    = PRE;
            cmd_nxt      = C_PRE;
            cnt_nxt      = TRP_LD;
            row_open_nxt = 1'b0;
          end else begin
            state_nxt = CMD;
            cmd_nxt   = cur_write ? C_WRITE : C_READ;
          end
        end
      end
      PRE: begin
        if (cnt == '0) begin
          state_nxt    = ACT;
          cmd_nxt      = C_ACT;
          cnt_nxt      = TRCD_LD;
          row_open_nxt = 1'b1;
          open_row_nxt = cur_row;
        end
      end
      ACT: begin
        if (cnt == '0) begin
          state_nxt = CMD;
          cmd_nxt   = cur_write ? C_WRITE : C_READ;
        end
      end
      CMD: begin
        if (cur_write) begin
          state_nxt   = WREC;
          cnt_nxt     = TWR_LD;
          resp_set_wr = 1'b1;
        end else begin
          state_nxt = RWAIT;
        end
      end
      RWAIT: begin
        if (DRAM_valid) begin
          state_nxt   = IDLE;
          resp_set_rd = 1'b1;
        end
      end
      WREC: begin
        if (cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches, captured on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_write <= 1'b0;
      lat_row   <= '0;
      lat_col   <= '0;
      lat_wstrb <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_write <= req_write;
      lat_row   <= req_addr[22:12];
      lat_col   <= req_addr[11:2];
      lat_wstrb <= req_wstrb;
      lat_wdata <= req_wdata;
    end
  end

  // Registered pin drive: NOP unless a command was chosen this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      DRAM_CSn  <= 1'b1;
      DRAM_RASn <= 1'b1;
      DRAM_CASn <= 1'b1;
      DRAM_WEn  <= 4'hF;
      DRAM_A    <= '0;
      DRAM_D    <= '0;
    end else begin
      DRAM_CSn  <= 1'b1;
      DRAM_RASn <= 1'b1;
      DRAM_CASn <= 1'b1;
      DRAM_WEn  <= 4'hF;
      DRAM_A    <= '0;
      DRAM_D    <= '0;
      case (cmd_nxt)
        C_ACT: begin
          DRAM_CSn  <= 1'b0;
          DRAM_RASn <= 1'b0;
          DRAM_A    <= cur_row;
        end
        C_PRE: begin
          DRAM_CSn  <= 1'b0;
          DRAM_RASn <= 1'b0;
          DRAM_WEn  <= 4'h0;
        end
        C_READ: begin
          DRAM_CSn  <= 1'b0;
          DRAM_CASn <= 1'b0;
          DRAM_A    <= {1'b0, cur_col};
        end
        C_WRITE: begin
          DRAM_CSn  <= 1'b0;
          DRAM_CASn <= 1'b0;
          DRAM_WEn  <= ~cur_wstrb;
          DRAM_A    <= {1'b0, cur_col};
          DRAM_D    <= cur_wdata;
        end
        default: ;
      endcase
    end
  end

  // Response holding register; held until the bus takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else if (resp_set_rd) begin
      resp_valid <= 1'b1;
      resp_rdata <= DRAM_Q;
    end else if (resp_set_wr) begin
      resp_valid <= 1'b1;
      resp_rdata <= '0;
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: a small DRAM pin model answers READs, a command log
// captures every non-NOP pin cycle, and a response scoreboard checks rdata.
`timescale 1ns/1ps
module tb_dram_ctrl;

  localparam int TRCD = 5;
  localparam int TRP  = 5;
  localparam int TWR  = 5;

  localparam logic [2:0] K_ACT = 3'd1;
  localparam logic [2:0] K_PRE = 3'd2;
  localparam logic [2:0] K_RD  = 3'd3;
  localparam logic [2:0] K_WR  = 3'd4;
  localparam logic [2:0] K_BAD = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_wstrb = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        DRAM_CSn, DRAM_RASn, DRAM_CASn;
  logic [3:0]  DRAM_WEn;
  logic [10:0] DRAM_A;
  logic [31:0] DRAM_D;
  logic [31:0] DRAM_Q = '0;
  logic        DRAM_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  dram_ctrl #(.TRCD(TRCD), .TRP(TRP), .TWR(TWR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .DRAM_CSn(DRAM_CSn), .DRAM_RASn(DRAM_RASn), .DRAM_CASn(DRAM_CASn),
    .DRAM_WEn(DRAM_WEn), .DRAM_A(DRAM_A), .DRAM_D(DRAM_D),
    .DRAM_Q(DRAM_Q), .DRAM_valid(DRAM_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Command log: every cycle whose pins are not exactly NOP.
  typedef struct {
    int          c;
    logic [2:0]  k;
    logic [10:0] a;
    logic [31:0] d;
    logic [3:0]  wen;
  } cmd_rec_t;
  cmd_rec_t log_q[$];

  always @(negedge clk) begin
    cmd_rec_t r;
    if (!(DRAM_CSn === 1'b1 && DRAM_RASn === 1'b1 && DRAM_CASn === 1'b1 &&
          DRAM_WEn === 4'hF && DRAM_A === 11'h0 && DRAM_D === 32'h0)) begin
      r.c = cyc; r.a = DRAM_A; r.d = DRAM_D; r.wen = DRAM_WEn;
      if (!DRAM_CSn && !DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'hF)      r.k = K_ACT;
      else if (!DRAM_CSn && !DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'h0) r.k = K_PRE;
      else if (!DRAM_CSn && DRAM_RASn && !DRAM_CASn && DRAM_WEn == 4'hF) r.k = K_RD;
      else if (!DRAM_CSn && DRAM_RASn && !DRAM_CASn)                     r.k = K_WR;
      else                                                               r.k = K_BAD;
      log_q.push_back(r);
    end
  end

  // DRAM model: answers a READ three cycles later with rd_data.
  int          rd_cnt = 0;
  logic [31:0] rd_data = '0;
  bit          mute = 1'b0;
  bit          inj_valid = 1'b0;

  always @(negedge clk) begin
    DRAM_valid = 1'b0;
    DRAM_Q     = 32'h0;
    if (inj_valid) begin
      DRAM_valid = 1'b1;
      DRAM_Q     = 32'hFFFF_FFFF;
    end
    if (rd_cnt == 1) begin
      DRAM_valid = 1'b1;
      DRAM_Q     = rd_data;
    end
    if (rd_cnt != 0) rd_cnt--;
    if (!mute && !DRAM_CSn && DRAM_RASn && !DRAM_CASn && DRAM_WEn == 4'hF) rd_cnt = 3;
  end

  // Response scoreboard.
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got response rdata=%h, required no response", resp_rdata);
      end else begin
        e = exp_q.pop_front();
        if (resp_rdata !== e) begin
          errors++;
          $display("FAIL resp_rdata: got %h, required %h", resp_rdata, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wd, output int t_acc);
    int n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wstrb = strb; req_wdata = wd;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    t_acc = cyc;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_resp_timeout: %0d responses outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_in_rst: got %b, required 0", req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_after: got %b, required 1", req_ready);
    end
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_resp: got valid=%b rdata=%h, required 0/0", resp_valid, resp_rdata);
    end
    checks++;
    if (DRAM_CSn !== 1'b1 || DRAM_RASn !== 1'b1 || DRAM_CASn !== 1'b1 || DRAM_WEn !== 4'hF ||
        DRAM_A !== 11'h0 || DRAM_D !== 32'h0) begin
      errors++;
      $display("FAIL reset_pins: got CSn=%b RASn=%b CASn=%b WEn=%h A=%h D=%h, required NOP",
               DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, DRAM_D);
    end
  endtask

  task automatic test_closed_read();
    int t;
    log_q.delete();
    rd_data = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    issue(1'b0, 32'h0001_2344, 4'h0, 32'h0, t);
    drain("closed_read");
    checks++;
    if (log_q.size() != 2) begin
      errors++; $display("FAIL closed_read_cmds: got %0d commands, required 2", log_q.size());
    end else begin
      checks++;
      if (log_q[0].k !== K_ACT || log_q[0].c != t + 1 || log_q[0].a !== 11'h012) begin
        errors++;
        $display("FAIL closed_read_act: got kind=%0d cyc=%0d A=%h, required kind=%0d cyc=%0d A=012",
                 log_q[0].k, log_q[0].c, log_q[0].a, K_ACT, t + 1);
      end
      checks++;
      if (log_q[1].k !== K_RD || log_q[1].c != t + 1 + TRCD || log_q[1].a !== 11'h0D1) begin
        errors++;
        $display("FAIL closed_read_rd: got kind=%0d cyc=%0d A=%h, required kind=%0d cyc=%0d A=0d1",
                 log_q[1].k, log_q[1].c, log_q[1].a, K_RD, t + 1 + TRCD);
      end
    end
  endtask

  task automatic test_row_hit();
    int t;
    log_q.delete();
    rd_data = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    issue(1'b0, 32'h0001_2348, 4'h0, 32'h0, t);
    drain("row_hit");
    checks++;
    if (log_q.size() != 1) begin
      errors++; $display("FAIL row_hit_cmds: got %0d commands, required 1", log_q.size());
    end else begin
      checks++;
      if (log_q[0].k !== K_RD || log_q[0].c != t + 1 || log_q[0].a !== 11'h0D2) begin
        errors++;
        $display("FAIL row_hit_rd: got kind=%0d cyc=%0d A=%h, required kind=%0d cyc=%0d A=0d2",
                 log_q[0].k, log_q[0].c, log_q[0].a, K_RD, t + 1);
      end
    end
  endtask

  task automatic test_row_miss();
    int t;
    log_q.delete();
    rd_data = 32'hCAFE_F00D;
    exp_q.push_back(32'hCAFE_F00D);
    issue(1'b0, 32'h0040_0000, 4'h0, 32'h0, t);
    drain("row_miss");
    checks++;
    if (log_q.size() != 3) begin
      errors++; $display("FAIL row_miss_cmds: got %0d commands, required 3", log_q.size());
    end else begin
      checks++;
      if (log_q[0].k !== K_PRE || log_q[0].c != t + 1) begin
        errors++;
        $display("FAIL row_miss_pre: got kind=%0d cyc=%0d, required kind=%0d cyc=%0d",
                 log_q[0].k, log_q[0].c, K_PRE, t + 1);
      end
      checks++;
      if (log_q[1].k !== K_ACT || log_q[1].c != t + 1 + TRP || log_q[1].a !== 11'h400) begin
        errors++;
        $display("FAIL row_miss_act: got kind=%0d cyc=%0d A=%h, required kind=%0d cyc=%0d A=400",
                 log_q[1].k, log_q[1].c, log_q[1].a, K_ACT, t + 1 + TRP);
      end
      checks++;
      if (log_q[2].k !== K_RD || log_q[2].c != t + 1 + TRP + TRCD || log_q[2].a !== 11'h000) begin
        errors++;
        $display("FAIL row_miss_rd: got kind=%0d cyc=%0d A=%h, required kind=%0d cyc=%0d A=000",
                 log_q[2].k, log_q[2].c, log_q[2].a, K_RD, t + 1 + TRP + TRCD);
      end
    end
  endtask

  task automatic test_write();
    int t;
    log_q.delete();
    exp_q.push_back(32'h0);
    issue(1'b1, 32'h0040_0010, 4'b0101, 32'hA5A5_A5A5, t);
    for (int k = 1; k <= TWR + 2; k++) begin
      @(negedge clk);
      if (k == 2) begin
        checks++;
        if (resp_valid !== 1'b1) begin
          errors++; $display("FAIL write_resp_valid: got %b at cyc %0d, required 1", resp_valid, cyc);
        end
      end
      if (k >= 2 && k <= TWR + 1) begin
        checks++;
        if (req_ready !== 1'b0) begin
          errors++; $display("FAIL write_twr_ready: got %b at cyc %0d, required 0", req_ready, cyc);
        end
      end
      if (k == TWR + 2) begin
        checks++;
        if (req_ready !== 1'b1) begin
          errors++; $display("FAIL write_ready_after: got %b at cyc %0d, required 1", req_ready, cyc);
        end
      end
    end
    drain("write");
    checks++;
    if (log_q.size() != 1) begin
      errors++; $display("FAIL write_cmds: got %0d commands, required 1", log_q.size());
    end else begin
      checks++;
      if (log_q[0].k !== K_WR || log_q[0].c != t + 1 || log_q[0].a !== 11'h004 ||
          log_q[0].wen !== 4'b1010 || log_q[0].d !== 32'hA5A5_A5A5) begin
        errors++;
        $display("FAIL write_cmd: got kind=%0d cyc=%0d A=%h WEn=%b D=%h, required kind=%0d cyc=%0d A=004 WEn=1010 D=a5a5a5a5",
                 log_q[0].k, log_q[0].c, log_q[0].a, log_q[0].wen, log_q[0].d, K_WR, t + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int t;
    int n = 0;
    resp_ready = 1'b0;
    rd_data = 32'h0BAD_F00D;
    exp_q.push_back(32'h0BAD_F00D);
    issue(1'b0, 32'h0040_0020, 4'h0, 32'h0, t);
    while (resp_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++; $display("FAIL backpressure_resp_timeout: resp_valid=%b, required 1", resp_valid);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h0BAD_F00D || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold: got valid=%b rdata=%h ready=%b, required 1/0badf00d/0",
                 resp_valid, resp_rdata, req_ready);
      end
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    drain("backpressure");
  endtask

  task automatic test_back_to_back();
    int t;
    int t0;
    int n = 0;
    resp_ready = 1'b0;
    rd_data = 32'h1111_2222;
    exp_q.push_back(32'h1111_2222);
    issue(1'b0, 32'h0040_0040, 4'h0, 32'h0, t0);
    while (resp_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    log_q.delete();
    rd_data = 32'h3333_4444;
    exp_q.push_back(32'h3333_4444);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0040_0044;
    resp_ready = 1'b1;
    @(negedge clk);
    t = cyc;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_same_cycle: got ready=%b resp_valid=%b, required 1/1", req_ready, resp_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain("b2b");
    checks++;
    if (log_q.size() != 1) begin
      errors++; $display("FAIL b2b_cmds: got %0d commands, required 1", log_q.size());
    end else begin
      checks++;
      if (log_q[0].k !== K_RD || log_q[0].c != t + 1 || log_q[0].a !== 11'h011) begin
        errors++;
        $display("FAIL b2b_rd: got kind=%0d cyc=%0d A=%h, required kind=%0d cyc=%0d A=011",
                 log_q[0].k, log_q[0].c, log_q[0].a, K_RD, t + 1);
      end
    end
  endtask

  task automatic test_reset_in_rwait();
    int t;
    mute = 1'b1;
    log_q.delete();
    issue(1'b0, 32'h0040_0030, 4'h0, 32'h0, t);
    repeat (3) @(negedge clk);
    checks++;
    if (log_q.size() != 1 || log_q[0].k !== K_RD) begin
      errors++; $display("FAIL rwait_setup: got %0d commands, required one READ", log_q.size());
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL rwait_rst_ready: got %b, required 0", req_ready);
    end
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    inj_valid = 1'b1;
    @(posedge clk); #1;
    inj_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++; $display("FAIL rwait_dropped: got resp_valid=%b at cyc %0d, required 0", resp_valid, cyc);
      end
    end
    mute = 1'b0;
    log_q.delete();
    rd_data = 32'h5555_AAAA;
    exp_q.push_back(32'h5555_AAAA);
    issue(1'b0, 32'h0040_0000, 4'h0, 32'h0, t);
    drain("after_rst");
    checks++;
    if (log_q.size() != 2) begin
      errors++; $display("FAIL after_rst_cmds: got %0d commands, required 2", log_q.size());
    end else begin
      checks++;
      if (log_q[0].k !== K_ACT || log_q[0].c != t + 1 || log_q[0].a !== 11'h400) begin
        errors++;
        $display("FAIL after_rst_act: got kind=%0d cyc=%0d A=%h, required kind=%0d cyc=%0d A=400",
                 log_q[0].k, log_q[0].c, log_q[0].a, K_ACT, t + 1);
      end
      checks++;
      if (log_q[1].k !== K_RD || log_q[1].c != t + 1 + TRCD) begin
        errors++;
        $display("FAIL after_rst_rd: got kind=%0d cyc=%0d, required kind=%0d cyc=%0d",
                 log_q[1].k, log_q[1].c, K_RD, t + 1 + TRCD);
      end
    end
  endtask

  initial begin
    test_reset();
    test_closed_read();
    test_row_hit();
    test_row_miss();
    test_write();
    test_backpressure();
    test_back_to_back();
    test_reset_in_rwait();
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
